// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - EX-stage multi-cycle shift-add multiply sequencer with pipeline stall
module mul_seq_ctrl #(
    parameter int          WIDTH    = 32,
    parameter logic [3:0]  MUL_CODE = 4'b1111
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_next;
    logic               start;
    logic               last_iter;

    assign start     = valid_i & ~flush_i & (ALUCtrl_i == MUL_CODE) & (state == IDLE);
    assign acc_next  = mplier[0] ? acc + mcand : acc;
    // Stop as soon as no multiplier bits remain, so small operands finish early.
    assign last_iter = ((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));

    // Stall is combinational so the front end freezes in the same cycle the mul is seen.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE:    stall_o = start;
                BUSY:    stall_o = ~flush_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    assign busy_o = ~rst_i & (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last_iter) begin
                            result_o <= acc_next;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed scoreboard bench for mul_seq_ctrl
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu;
    logic        valid;
    logic        flush;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'h0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(32), .MUL_CODE(4'b1111)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ALUCtrl_i (alu),
        .valid_i   (valid),
        .flush_i   (flush),
        .data1_i   (d1),
        .data2_i   (d2),
        .stall_o   (stall),
        .done_o    (done),
        .result_o  (result),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int kof(input logic [31:0] b);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) k = i + 1;
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy},  32'd0);
        chk({tag, "_done"},  {31'b0, done},  32'd0);
        step();
    endtask

    // Issues one mul and checks stall over T..T+k and the done pulse at T+k+1.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        int          k;
        logic [63:0] full;
        logic [31:0] exp;
        k    = kof(b);
        full = {32'b0, a} * {32'b0, b};
        sb_q.push_back(full[31:0]);
        alu = 4'hF; valid = 1'b1; flush = 1'b0; d1 = a; d2 = b;
        @(negedge clk);
        chk({tag, "_start_stall"}, {31'b0, stall}, 32'd1);
        chk({tag, "_start_busy"},  {31'b0, busy},  32'd0);
        chk({tag, "_start_done"},  {31'b0, done},  32'd0);
        step();
        alu = 4'h2; d1 = $urandom; d2 = $urandom;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            chk({tag, "_busy_stall"}, {31'b0, stall}, 32'd1);
            chk({tag, "_busy_busy"},  {31'b0, busy},  32'd1);
            chk({tag, "_busy_done"},  {31'b0, done},  32'd0);
            step();
            if (i == k) alu = 4'hF;
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done},  32'd1);
        chk({tag, "_done_stall"}, {31'b0, stall}, 32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_result"}, result, exp);
            last_result = exp;
        end
        step();
        alu = 4'h0; valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alu = 4'hF; valid = 1'b1; flush = 1'b0; d1 = 32'd3; d2 = 32'd5;
        step();
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        step();
        rst = 1'b0; valid = 1'b0; alu = 4'h0;
        @(negedge clk);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_result", result,        32'd0);
        step();

        // Non-mul codes and invalid mul never start.
        valid = 1'b1; alu = 4'b0010; idle_cycle("pass_add");
        alu = 4'b0110;               idle_cycle("pass_sub");
        alu = 4'b0000;               idle_cycle("pass_and");
        valid = 1'b0; alu = 4'hF;    idle_cycle("inval_mul");
        idle_cycle("inval_mul_after");

        run_mul(32'd3, 32'd5, "m3x5");
        idle_cycle("m3x5_after");
        run_mul(32'd7, 32'd0, "m7x0");
        idle_cycle("m7x0_after");
        run_mul(32'h1234_5678, 32'd1, "mx1");
        idle_cycle("mx1_after");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mfull");
        idle_cycle("mfull_after");
        run_mul(32'hDEAD_BEEF, 32'h0000_0A5C, "mrand");
        idle_cycle("mrand_after");

        // Back-to-back: second mul starts the cycle right after DONE.
        run_mul(32'd4, 32'd4, "b2b_a");
        run_mul(32'd9, 32'd2, "b2b_b");
        idle_cycle("b2b_after");

        // Flush mid-multiply.
        alu = 4'hF; valid = 1'b1; d1 = 32'd6; d2 = 32'd7;
        @(negedge clk); chk("fl_t0_stall", {31'b0, stall}, 32'd1);
        step();
        @(negedge clk); chk("fl_t1_busy", {31'b0, busy}, 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_t2_stall", {31'b0, stall}, 32'd0);
        chk("fl_t2_busy",  {31'b0, busy},  32'd1);
        step();
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("fl_t3_busy",   {31'b0, busy}, 32'd0);
        chk("fl_t3_done",   {31'b0, done}, 32'd0);
        chk("fl_t3_result", result,        last_result);
        step();
        idle_cycle("fl_t4");

        // Flush in IDLE suppresses start.
        flush = 1'b1; valid = 1'b1; alu = 4'hF;
        idle_cycle("fl_idle");
        flush = 1'b0; valid = 1'b0;
        idle_cycle("fl_idle_after");

        // Reset mid-multiply.
        alu = 4'hF; valid = 1'b1; d1 = 32'd6; d2 = 32'd7;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_stall", {31'b0, stall}, 32'd0);
        chk("rm_busy",  {31'b0, busy},  32'd0);
        step();
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("rm_result", result,        32'd0);
        chk("rm_done",   {31'b0, done}, 32'd0);
        chk("rm_busy2",  {31'b0, busy}, 32'd0);
        step();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
